// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: configurable width and oversampling, runtime parity
// and stop-bit selection, start-glitch rejection, break handling, error reporting.
module uart_rx_ext #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx,
    input  logic                 i_bd_tick,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [1:0]             cfg_mode;
    logic                   cfg_two_stop;
    logic                   par_err;
    logic                   frm_err;

    logic parity_en;
    logic parity_odd;
    logic half_hit;
    logic full_hit;
    logic stop_last;
    logic frm_next;

    assign parity_en  = (cfg_mode == 2'b01) || (cfg_mode == 2'b10);
    assign parity_odd = (cfg_mode == 2'b10);
    assign half_hit   = i_bd_tick && (tick_cnt == HALF_LAST);
    assign full_hit   = i_bd_tick && (tick_cnt == FULL_LAST);
    assign stop_last  = (bit_cnt == BW'(cfg_two_stop));
    assign frm_next   = frm_err | ~rx_s;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            cfg_mode     <= 2'b00;
            cfg_two_stop <= 1'b0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            o_data       <= '0;
            o_rx_done    <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state        <= START;
                        tick_cnt     <= '0;
                        cfg_mode     <= i_parity_mode;
                        cfg_two_stop <= i_two_stop;
                        par_err      <= 1'b0;
                        frm_err      <= 1'b0;
                        o_busy       <= 1'b1;
                    end
                end
                START: begin
                    if (half_hit) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else if (i_bd_tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (full_hit) begin
                        tick_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + BW'(1);
                        if (bit_cnt == DATA_LAST) begin
                            if (parity_en) begin
                                state <= PARITY;
                            end else begin
                                state   <= STOP;
                                bit_cnt <= '0;
                            end
                        end
                    end else if (i_bd_tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                PARITY: begin
                    if (full_hit) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        par_err  <= (^shift_reg) ^ rx_s ^ parity_odd;
                        state    <= STOP;
                    end else if (i_bd_tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                STOP: begin
                    if (full_hit) begin
                        tick_cnt <= '0;
                        if (stop_last) begin
                            o_data       <= shift_reg;
                            o_parity_err <= par_err;
                            o_frame_err  <= frm_next;
                            o_rx_done    <= 1'b1;
                            o_busy       <= 1'b0;
                            state        <= frm_next ? BREAK_WAIT : IDLE;
                        end else begin
                            frm_err <= frm_next;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else if (i_bd_tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                BREAK_WAIT: begin
                    // Hold off until the line releases so a break yields one frame
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
